wb_per_bridge: RTL and testbench
================================

WB_PER_BRIDGE -- requirements
Module: wb_per_bridge

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the base of the 32 KiB peripheral window (bits [14:0] ignored).
REQ-002 The module SHALL have parameter RD_WAIT, default 0, range 0..7, giving extra cycles between per_en_o and read-data capture.
REQ-003 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  reset; synchronous and active-high.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-006 wbs_sel_i  input  4  byte-lane selects; only [1:0] are used.
REQ-007 wbs_adr_i  input  32  byte address.
REQ-008 wbs_dat_i  input  32  write data; only [15:0] are used.
REQ-009 wbs_ack_o  output  1  single-cycle transfer acknowledge.
REQ-010 wbs_dat_o  output  32  read data: {16'h0000, captured 16-bit word}.
REQ-011 per_en_o  output  1  openMSP430 peripheral enable, one-cycle pulse.
REQ-012 per_we_o  output  2  byte write enables: [1] high byte, [0] low byte.
REQ-013 per_addr_o  output  14  peripheral word address.
REQ-014 per_din_o  output  16  peripheral write data.
REQ-015 per_dout_i  input  16  peripheral read data.

Function
REQ-016 A request SHALL be wbs_cyc_i & wbs_stb_i sampled high in IDLE.
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and ACK.
REQ-018 IDLE->REQ on an in-window request with an effective lane; IDLE->ACK directly on an out-of-window request or a write with wbs_sel_i[1:0]==2'b00.
REQ-019 An access is in window when wbs_adr_i[31:15]==BASE_ADDR[31:15].
REQ-020 On IDLE->REQ, the module SHALL register per_addr_o=wbs_adr_i[14:1], per_din_o=wbs_dat_i[15:0], and per_we_o=wbs_we_i ? wbs_sel_i[1:0] : 2'b00.
REQ-021 per_en_o SHALL be high for exactly the one cycle spent in REQ; otherwise low, never asserted twice for one access.
REQ-022 REQ->ACK for writes, or for reads when RD_WAIT==0. Otherwise REQ->WAIT, and WAIT counts RD_WAIT-1 down to 0, then goes to ACK.
REQ-023 For reads, per_dout_i SHALL be captured on the cycle the FSM leaves REQ (RD_WAIT=0) or the last WAIT cycle.
REQ-024 Out-of-window and null-write accesses SHALL return 32'h0 and never assert per_en_o.
REQ-025 wbs_ack_o SHALL be high exactly in ACK, for one cycle. ACK->IDLE unconditionally.
REQ-026 wbs_dat_o SHALL hold the captured value from ACK until the next capture; it is 32'h0 after writes and out-of-window accesses.
REQ-027 Latency from request sample edge to ack, in-window: write 2 cycles; read 2+RD_WAIT cycles; out-of-window or null write 1 cycle.
REQ-028 If wbs_cyc_i drops in REQ or WAIT, the FSM SHALL go to IDLE next cycle with no ack; a write already pulsed is not undone.
REQ-029 Back-to-back: a request present in the IDLE cycle after ACK SHALL be accepted; acks are never on consecutive cycles.
REQ-030 per_addr_o, per_din_o and per_we_o SHALL remain stable from REQ through ACK.

Reset
REQ-031 While wb_rst_i is high at a clock edge, the module SHALL set state=IDLE, wbs_ack_o=0, wbs_dat_o=0, per_en_o=0, per_we_o=0, per_addr_o=0, per_din_o=0 and wait counter=0.
REQ-032 Reset mid-transfer SHALL abort the transfer without ack; the first request SHALL be accepted in the cycle after wb_rst_i falls.

Structure
REQ-033 Package wb_per_bridge_pkg SHALL hold the FSM state enum, the window width constant (15) and the peripheral address/data widths (14/16).
REQ-034 No sub-module SHALL be used; FSM, wait counter and capture register SHALL reside in one module.

Verification
REQ-035 Write 0x3000_0104, dat 0x0000_ABCD, sel 4'b0011 -> per_en pulse 1 cycle with per_addr 14'h082, per_we 2'b11, per_din 16'hABCD; ack 2 cycles after request.
REQ-036 Read 0x3000_0010 with per_dout_i=16'h1234, RD_WAIT=0 -> wbs_dat_o 32'h0000_1234 with ack at cycle 2; with RD_WAIT=3 -> ack at cycle 5.
REQ-037 Write sel 4'b0010 -> per_we 2'b10. Write sel 4'b1100 -> no per_en, ack at cycle 1.
REQ-038 Read 0x2000_0000 -> no per_en, ack at cycle 1, wbs_dat_o 32'h0.
REQ-039 wbs_cyc_i dropped in WAIT (RD_WAIT=4), and separately wb_rst_i in REQ -> no ack, FSM IDLE, next request served normally.
REQ-040 Back-to-back writes with stb held -> exactly one per_en per access and non-consecutive acks.

Source files
------------

// File: rtl/wb_per_bridge_pkg.sv
// Shared types and widths for the Wishbone to openMSP430 peripheral bridge.
// Holds the FSM state encoding, the window width and the peripheral bus widths.
package wb_per_bridge_pkg;

  localparam int WIN_W   = 15;
  localparam int PADDR_W = 14;
  localparam int PDATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_per_bridge.sv
// Wishbone classic slave that maps a 32 KiB window onto an openMSP430 peripheral bus.
// Ports: wb_clk_i/wb_rst_i, wbs_* Wishbone slave, per_* peripheral master.
module wb_per_bridge
  import wb_per_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RD_WAIT   = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic                 per_en_o,
  output logic [1:0]           per_we_o,
  output logic [PADDR_W-1:0]   per_addr_o,
  output logic [PDATA_W-1:0]   per_din_o,
  input  logic [PDATA_W-1:0]   per_dout_i
);

  localparam logic [2:0] LP_CNT_INIT =
    (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_cnt;
  logic                 r_wr;
  logic [1:0]           r_we;
  logic [PADDR_W-1:0]   r_addr;
  logic [PDATA_W-1:0]   r_din;
  logic [PDATA_W-1:0]   r_dat;

  logic w_req;
  logic w_inwin;
  logic w_null;
  logic w_go;
  logic w_unused;

  assign w_req   = wbs_cyc_i & wbs_stb_i;
  assign w_inwin = wbs_adr_i[31:WIN_W] == BASE_ADDR[31:WIN_W];
  assign w_null  = wbs_we_i & (wbs_sel_i[1:0] == 2'b00);
  // Only in-window accesses with a live lane touch the peripheral.
  assign w_go    = w_inwin & ~w_null;

  assign w_unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[0],
                      BASE_ADDR[WIN_W-1:0]};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req)
          w_state_nxt = w_go ? S_REQ : S_ACK;
      end
      S_REQ: begin
        if (!wbs_cyc_i)
          w_state_nxt = S_IDLE;
        else if (r_wr || RD_WAIT == 0)
          w_state_nxt = S_ACK;
        else
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!wbs_cyc_i)
          w_state_nxt = S_IDLE;
        else if (r_cnt == 3'd0)
          w_state_nxt = S_ACK;
      end
      S_ACK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt  <= 3'd0;
      r_wr   <= 1'b0;
      r_we   <= 2'b00;
      r_addr <= '0;
      r_din  <= '0;
      r_dat  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_go) begin
              r_addr <= wbs_adr_i[WIN_W-1:1];
              r_din  <= wbs_dat_i[PDATA_W-1:0];
              r_we   <= wbs_we_i ? wbs_sel_i[1:0] : 2'b00;
              r_wr   <= wbs_we_i;
            end else begin
              r_dat  <= '0;
            end
          end
        end
        S_REQ: begin
          if (wbs_cyc_i) begin
            if (r_wr)
              r_dat <= '0;
            else if (RD_WAIT == 0)
              r_dat <= per_dout_i;
            else
              r_cnt <= LP_CNT_INIT;
          end
        end
        S_WAIT: begin
          if (wbs_cyc_i) begin
            if (r_cnt == 3'd0)
              r_dat <= per_dout_i;
            else
              r_cnt <= r_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign per_en_o   = (r_state == S_REQ);
  assign wbs_ack_o  = (r_state == S_ACK);
  assign per_we_o   = r_we;
  assign per_addr_o = r_addr;
  assign per_din_o  = r_din;
  assign wbs_dat_o  = {16'h0000, r_dat};

endmodule

// File: tb/tb_wb_per_bridge.sv
// Directed scoreboard bench for wb_per_bridge with RD_WAIT 0, 3 and 4.
// One request line set is steered to the selected instance.
module tb_wb_per_bridge;
  import wb_per_bridge_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [15:0] dout;
  int          tgt;

  logic        cyc_v [3];
  logic        stb_v [3];
  logic        ack   [3];
  logic [31:0] rdat  [3];
  logic        en    [3];
  logic [1:0]  pwe   [3];
  logic [13:0] pad   [3];
  logic [15:0] pdin  [3];

  logic        m_ack, m_en;
  logic [31:0] m_dat;
  logic [1:0]  m_we;
  logic [13:0] m_addr;
  logic [15:0] m_din;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cyc_v[i] = cyc && (tgt == i);
      stb_v[i] = stb && (tgt == i);
    end
    m_ack  = ack[tgt];
    m_en   = en[tgt];
    m_dat  = rdat[tgt];
    m_we   = pwe[tgt];
    m_addr = pad[tgt];
    m_din  = pdin[tgt];
  end

  wb_per_bridge #(.RD_WAIT(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_v[0]), .wbs_stb_i(stb_v[0]), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]),
    .per_en_o(en[0]), .per_we_o(pwe[0]), .per_addr_o(pad[0]),
    .per_din_o(pdin[0]), .per_dout_i(dout)
  );

  wb_per_bridge #(.RD_WAIT(3)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_v[1]), .wbs_stb_i(stb_v[1]), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]),
    .per_en_o(en[1]), .per_we_o(pwe[1]), .per_addr_o(pad[1]),
    .per_din_o(pdin[1]), .per_dout_i(dout)
  );

  wb_per_bridge #(.RD_WAIT(4)) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_v[2]), .wbs_stb_i(stb_v[2]), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack[2]), .wbs_dat_o(rdat[2]),
    .per_en_o(en[2]), .per_we_o(pwe[2]), .per_addr_o(pad[2]),
    .per_din_o(pdin[2]), .per_dout_i(dout)
  );

  int nchk = 0;
  int nerr = 0;

  int consec = 0;
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (m_ack && prev_ack) consec = consec + 1;
    prev_ack = m_ack;
  end

  typedef struct {
    string       tag;
    int          lat;
    int          nen;
    logic [1:0]  we;
    logic [13:0] addr;
    logic [15:0] din;
    logic [31:0] dat;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk = nchk + 1;
    assert (obs === exp) else begin
      nerr = nerr + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input int t,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [3:0] s,
                      input logic [15:0] pd, input bit hold,
                      input int e_lat, input int e_nen,
                      input logic [1:0] e_we, input logic [13:0] e_addr,
                      input logic [15:0] e_din, input logic [31:0] e_dat);
    exp_t e;
    exp_t g;
    int cycles;
    int nen;
    logic [1:0]  c_we;
    logic [13:0] c_addr;
    logic [15:0] c_din;
    e.tag = tag; e.lat = e_lat; e.nen = e_nen; e.we = e_we;
    e.addr = e_addr; e.din = e_din; e.dat = e_dat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    tgt = t; adr = a; wdat = d; we = w; sel = s; dout = pd;
    cyc = 1'b1; stb = 1'b1;
    cycles = 0; nen = 0;
    c_we = '0; c_addr = '0; c_din = '0;
    @(posedge clk);
    while (cycles < 30) begin
      @(negedge clk);
      cycles = cycles + 1;
      if (m_en) begin
        nen = nen + 1;
        c_we = m_we; c_addr = m_addr; c_din = m_din;
      end
      if (m_ack) break;
    end
    g = sbq.pop_front();
    chk({g.tag, "_lat"}, 32'(cycles), 32'(g.lat));
    chk({g.tag, "_dat"}, m_dat, g.dat);
    chk({g.tag, "_nen"}, 32'(nen), 32'(g.nen));
    if (g.nen > 0) begin
      chk({g.tag, "_we"}, 32'(c_we), 32'(g.we));
      chk({g.tag, "_addr"}, 32'(c_addr), 32'(g.addr));
      chk({g.tag, "_din"}, 32'(c_din), 32'(g.din));
      chk({g.tag, "_stable"}, {m_we, m_addr, m_din},
          {g.we, g.addr, g.din});
    end
    if (!hold) begin
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  initial begin : stim
    int acks;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; wdat = '0; dout = '0; tgt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_dat", rdat[0], 32'h0);
    chk("rst_en", 32'(en[0]), 32'd0);
    chk("rst_per", {pwe[0], pad[0], pdin[0]}, 32'h0);
    chk("rst_state", 32'(u0.r_state), 32'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    xfer("wr_full", 0, 32'h3000_0104, 32'h0000_ABCD, 1'b1, 4'b0011,
         16'h0, 1'b0, 2, 1, 2'b11, 14'h082, 16'hABCD, 32'h0);
    xfer("rd_w0", 0, 32'h3000_0010, 32'h0, 1'b0, 4'b0011,
         16'h1234, 1'b0, 2, 1, 2'b00, 14'h008, 16'h0000, 32'h0000_1234);
    xfer("rd_w3", 1, 32'h3000_0010, 32'h0, 1'b0, 4'b0011,
         16'h1234, 1'b0, 5, 1, 2'b00, 14'h008, 16'h0000, 32'h0000_1234);
    xfer("wr_hi", 0, 32'h3000_0002, 32'hFFFF_5566, 1'b1, 4'b0010,
         16'h0, 1'b0, 2, 1, 2'b10, 14'h001, 16'h5566, 32'h0);
    xfer("rd_lo0", 0, 32'h3000_7FFE, 32'h0, 1'b0, 4'b0011,
         16'hA5A5, 1'b0, 2, 1, 2'b00, 14'h3FFF, 16'h0000, 32'h0000_A5A5);
    xfer("wr_null", 0, 32'h3000_0004, 32'h0000_7777, 1'b1, 4'b1100,
         16'h0, 1'b0, 1, 0, 2'b00, 14'h0, 16'h0, 32'h0);
    xfer("rd_oow", 1, 32'h2000_0000, 32'h0, 1'b0, 4'b0011,
         16'h9999, 1'b0, 1, 0, 2'b00, 14'h0, 16'h0, 32'h0);

    // Drop cyc in WAIT on the RD_WAIT=4 instance.
    @(posedge clk);
    #1;
    tgt = 2; adr = 32'h3000_0020; we = 1'b0; sel = 4'b0011;
    dout = 16'h4321; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ack) acks = acks + 1;
    end
    chk("abort_wait_noack", 32'(acks), 32'd0);
    chk("abort_wait_idle", 32'(u2.r_state), 32'(S_IDLE));
    chk("abort_wait_dat", m_dat, 32'h0);
    xfer("rd_w4", 2, 32'h3000_0020, 32'h0, 1'b0, 4'b0011,
         16'hBEEF, 1'b0, 6, 1, 2'b00, 14'h010, 16'h0000, 32'h0000_BEEF);

    // Reset while in REQ.
    @(posedge clk);
    #1;
    tgt = 0; adr = 32'h3000_1000; wdat = 32'h0000_1111; we = 1'b1;
    sel = 4'b0011; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_req_en", 32'(m_en), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack) acks = acks + 1;
    end
    chk("rst_req_noack", 32'(acks), 32'd0);
    chk("rst_req_idle", 32'(u0.r_state), 32'(S_IDLE));
    chk("rst_req_per", {pwe[0], pad[0], pdin[0]}, 32'h0);
    xfer("wr_after_rst", 0, 32'h3000_0006, 32'h0000_2468, 1'b1, 4'b0001,
         16'h0, 1'b0, 2, 1, 2'b01, 14'h003, 16'h2468, 32'h0);

    // Back-to-back writes with stb held.
    consec = 0;
    xfer("b2b_0", 0, 32'h3000_0100, 32'h0000_0001, 1'b1, 4'b0011,
         16'h0, 1'b1, 2, 1, 2'b11, 14'h080, 16'h0001, 32'h0);
    xfer("b2b_1", 0, 32'h3000_0102, 32'h0000_0002, 1'b1, 4'b0011,
         16'h0, 1'b1, 2, 1, 2'b11, 14'h081, 16'h0002, 32'h0);
    xfer("b2b_2", 0, 32'h3000_0104, 32'h0000_0003, 1'b1, 4'b0001,
         16'h0, 1'b0, 2, 1, 2'b01, 14'h082, 16'h0003, 32'h0);
    @(negedge clk);
    chk("b2b_noconsec", 32'(consec), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
